systolic_mm_controller: RTL and testbench

- Sequencer for the 5x5 output-stationary systolic array.
- Accepts a streamed K-deep matrix product: per beat, one column of A (a[0..4][k]) and one row of B (b[k][0..4]).
- Applies the triangular input skew, drives the per-PE clr/read/write vectors through CLEAR, FEED, FLUSH and DRAIN phases, and returns the 5x5 result one row per beat, bottom row first.
- Sits between the operand buffers and the array instance.

---
 rtl/systolic_mm_controller.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_mm_controller.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_controller.sv
// Sequencer for a 5x5 output-stationary systolic array: triangular operand skew,
// per-PE clear/accumulate/drain control and bottom-row-first result readout.

module systolic_mm_controller #(
    parameter int N  = 32,
    parameter int KW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KW-1:0]    k_len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5*N-1:0]   a_col,
    input  logic [5*N-1:0]   b_row,
    output logic [5*N-1:0]   arr_a,
    output logic [5*N-1:0]   arr_b,
    input  logic [5*N-1:0]   arr_bout,
    output logic [24:0]      pe_clr,
    output logic [24:0]      pe_read,
    output logic [24:0]      pe_write,
    output logic             res_valid,
    output logic [2:0]       res_row,
    output logic [5*N-1:0]   res_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [KW-1:0] K_ZERO     = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE      = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    FLUSH_LAST = 4'd8;
    localparam logic [3:0]    DRAIN_LAST = 4'd9;

    state_t          r_state;
    state_t          w_next;
    logic [KW-1:0]   r_k_len;
    logic [KW-1:0]   r_beat_cnt;
    logic [3:0]      r_phase_cnt;

    logic            r_busy;
    logic            r_done;
    logic            r_in_ready;
    logic            r_pe_clr_all;
    logic            r_pe_drain_all;
    logic            r_res_valid;
    logic [2:0]      r_res_row;
    logic [5*N-1:0]  r_res_data;

    logic            w_accept;
    logic            w_last_beat;
    logic            w_capture;
    logic            w_skew_clr;
    logic [5*N-1:0]  w_a_in;
    logic [5*N-1:0]  w_b_in;

    assign w_accept    = (r_state == S_FEED) && in_valid;
    assign w_last_beat = w_accept && (r_beat_cnt == (r_k_len - K_ONE));
    // Odd phase count in DRAIN is an even drain cycle d: the row has reached arr_bout.
    assign w_capture   = (r_state == S_DRAIN) && r_phase_cnt[0];
    assign w_skew_clr  = (r_state == S_CLEAR);
    // Stall cycles and all non-FEED cycles inject zero slots into every lane.
    assign w_a_in      = w_accept ? a_col : {(5*N){1'b0}};
    assign w_b_in      = w_accept ? b_row : {(5*N){1'b0}};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CLEAR;
                else       w_next = S_IDLE;
            end
            S_CLEAR: begin
                if (r_k_len == K_ZERO) w_next = S_FLUSH;
                else                   w_next = S_FEED;
            end
            S_FEED: begin
                if (w_last_beat) w_next = S_FLUSH;
                else             w_next = S_FEED;
            end
            S_FLUSH: begin
                if (r_phase_cnt == FLUSH_LAST) w_next = S_DRAIN;
                else                           w_next = S_FLUSH;
            end
            S_DRAIN: begin
                if (r_phase_cnt == DRAIN_LAST) w_next = S_DONE;
                else                           w_next = S_DRAIN;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job length capture, accepted-beat counter and FLUSH/DRAIN phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_len     <= K_ZERO;
            r_beat_cnt  <= K_ZERO;
            r_phase_cnt <= 4'd0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_k_len <= k_len;
            end else begin
                r_k_len <= r_k_len;
            end
            if (r_state == S_CLEAR) begin
                r_beat_cnt <= K_ZERO;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + K_ONE;
            end else begin
                r_beat_cnt <= r_beat_cnt;
            end
            if ((w_next != r_state) || ((r_state != S_FLUSH) && (r_state != S_DRAIN))) begin
                r_phase_cnt <= 4'd0;
            end else begin
                r_phase_cnt <= r_phase_cnt + 4'd1;
            end
        end
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_in_ready     <= 1'b0;
            r_pe_clr_all   <= 1'b0;
            r_pe_drain_all <= 1'b0;
        end else begin
            r_busy         <= (w_next != S_IDLE);
            r_done         <= (w_next == S_DONE);
            r_in_ready     <= (w_next == S_FEED);
            r_pe_clr_all   <= (w_next == S_CLEAR);
            r_pe_drain_all <= (w_next == S_DRAIN);
        end
    end

    // Result capture: bottom row exits the array first, one row every two drain cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_row   <= 3'd0;
            r_res_data  <= {(5*N){1'b0}};
        end else begin
            r_res_valid <= w_capture;
            if (w_capture) begin
                r_res_row  <= 3'd4 - r_phase_cnt[3:1];
                r_res_data <= arr_bout;
            end else begin
                r_res_row  <= r_res_row;
                r_res_data <= r_res_data;
            end
        end
    end

    // Triangular skew: lane g is delayed by g+1 register stages
    for (genvar g = 0; g < 5; g++) begin : g_lane
        logic [N-1:0] r_a_pipe [0:g];
        logic [N-1:0] r_b_pipe [0:g];

        // Skew shift register for lane g of A and B
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= g; s++) begin
                    r_a_pipe[s] <= {N{1'b0}};
                    r_b_pipe[s] <= {N{1'b0}};
                end
            end else if (w_skew_clr) begin
                for (int s = 0; s <= g; s++) begin
                    r_a_pipe[s] <= {N{1'b0}};
                    r_b_pipe[s] <= {N{1'b0}};
                end
            end else begin
                r_a_pipe[0] <= w_a_in[g*N +: N];
                r_b_pipe[0] <= w_b_in[g*N +: N];
                for (int s = g; s > 0; s--) begin
                    r_a_pipe[s] <= r_a_pipe[s-1];
                    r_b_pipe[s] <= r_b_pipe[s-1];
                end
            end
        end

        assign arr_a[g*N +: N] = r_a_pipe[g];
        assign arr_b[g*N +: N] = r_b_pipe[g];
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign pe_clr    = {25{r_pe_clr_all}};
    assign pe_read   = {25{r_pe_drain_all}};
    assign pe_write  = {25{r_pe_drain_all}};
    assign res_valid = r_res_valid;
    assign res_row   = r_res_row;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_systolic_mm_controller.sv
// Bench for systolic_mm_controller: closes the loop through a behavioural 5x5
// output-stationary array and checks rows against a plain matrix product.

module tb_systolic_mm_controller;

    localparam int N    = 32;
    localparam int KW   = 8;
    localparam int LW   = 5 * N;
    localparam int KMAX = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = {KW{1'b0}};
    logic            busy, done, in_ready, res_valid;
    logic            in_valid = 1'b0;
    logic [LW-1:0]   a_col = {LW{1'b0}};
    logic [LW-1:0]   b_row = {LW{1'b0}};
    logic [LW-1:0]   arr_a, arr_b, arr_bout, res_data;
    logic [24:0]     pe_clr, pe_read, pe_write;
    logic [2:0]      res_row;

    always #5 clk = ~clk;

    systolic_mm_controller #(.N(N), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .arr_a(arr_a), .arr_b(arr_b),
        .arr_bout(arr_bout), .pe_clr(pe_clr), .pe_read(pe_read),
        .pe_write(pe_write), .res_valid(res_valid), .res_row(res_row),
        .res_data(res_data)
    );

    // Behavioural array: A moves right, B moves down, drain shifts accumulators down the B path
    logic [N-1:0] m_acc [5][5];
    logic [N-1:0] m_ar  [5][5];
    logic [N-1:0] m_br  [5][5];
    logic [N-1:0] ain   [5][5];
    logic [N-1:0] bin   [5][5];

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (j == 0) ain[i][j] = arr_a[i*N +: N];
                else        ain[i][j] = m_ar[i][j-1];
                if (i == 0) bin[i][j] = arr_b[j*N +: N];
                else        bin[i][j] = m_br[i-1][j];
            end
        end
        for (int j = 0; j < 5; j++) arr_bout[j*N +: N] = m_br[4][j];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (pe_clr[5*i+j]) begin
                    m_acc[i][j] <= {N{1'b0}};
                    m_ar[i][j]  <= {N{1'b0}};
                    m_br[i][j]  <= {N{1'b0}};
                end else if (pe_read[5*i+j] && pe_write[5*i+j]) begin
                    m_acc[i][j] <= bin[i][j];
                    m_br[i][j]  <= m_acc[i][j];
                    m_ar[i][j]  <= ain[i][j];
                end else begin
                    m_acc[i][j] <= m_acc[i][j] + ain[i][j] * bin[i][j];
                    m_ar[i][j]  <= ain[i][j];
                    m_br[i][j]  <= bin[i][j];
                end
            end
        end
    end

    // Cycle counter and output monitor
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ready_cnt = 0;
    logic [2:0]    got_rows [$];
    logic [LW-1:0] got_data [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid) begin
            got_rows.push_back(res_row);
            got_data.push_back(res_data);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (in_ready) ready_cnt <= ready_cnt + 1;
    end

    // Reference data and observations
    logic [N-1:0]  ma [5][KMAX];
    logic [N-1:0]  mb [KMAX][5];
    logic [LW-1:0] exp_c [5];
    logic [2:0]    obs_row [5];
    logic [LW-1:0] obs_data [5];
    int obs_nrows, obs_ndone, obs_ready, obs_lat, obs_stalls;
    logic obs_busy;
    int id_lat;
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [LW-1:0] pack_a(input int k);
        logic [LW-1:0] v;
        for (int i = 0; i < 5; i++) v[i*N +: N] = ma[i][k];
        return v;
    endfunction

    function automatic logic [LW-1:0] pack_b(input int k);
        logic [LW-1:0] v;
        for (int j = 0; j < 5; j++) v[j*N +: N] = mb[k][j];
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_vec();
        logic [LW-1:0] v;
        for (int i = 0; i < 5; i++) v[i*N +: N] = N'($urandom);
        return v;
    endfunction

    task automatic randomize_mats();
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < KMAX; k++) begin
                ma[i][k] = N'($urandom);
                mb[k][i] = N'($urandom);
            end
    endtask

    // C = A*B modulo 2^N, straight from the definition
    task automatic compute_ref(input int k);
        logic [N-1:0] s;
        for (int r = 0; r < 5; r++)
            for (int j = 0; j < 5; j++) begin
                s = {N{1'b0}};
                for (int kk = 0; kk < k; kk++) s = s + ma[r][kk] * mb[kk][j];
                exp_c[r][j*N +: N] = s;
            end
    endtask

    // Drive one job (mode 0: no stalls, 1: alternate, 2: random) and gather what comes out
    task automatic run_job(input int k, input int mode, input bit poke);
        int base_rows, base_done, base_ready, t0, sent, guard;
        bit v, alt;
        base_rows  = got_rows.size();
        base_done  = done_cnt;
        base_ready = ready_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = k[KW-1:0];
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        k_len = KW'($urandom);
        sent = 0; guard = 0; alt = 1'b1; obs_stalls = 0;
        while (sent < k && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = alt; alt = ~alt; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            a_col    = v ? pack_a(sent) : rand_vec();
            b_row    = v ? pack_b(sent) : rand_vec();
            @(negedge clk);
            if (in_ready) begin
                if (v) sent++;
                else   obs_stalls++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        a_col    = rand_vec();
        b_row    = rand_vec();
        if (poke) begin
            start = 1'b1;
            k_len = 8'd3;
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (done_cnt == base_done && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        obs_lat   = (done_cnt == base_done) ? -1 : done_cyc - t0;
        obs_ndone = done_cnt - base_done;
        obs_ready = ready_cnt - base_ready;
        obs_busy  = busy;
        obs_nrows = got_rows.size() - base_rows;
        for (int r = 0; r < 5; r++) begin
            obs_row[r]  = 3'bxxx;
            obs_data[r] = {LW{1'bx}};
            if (r < obs_nrows) begin
                obs_row[r]  = got_rows[base_rows + r];
                obs_data[r] = got_data[base_rows + r];
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, in_ready, res_valid, res_row} !== 7'd0)
            $display("FAIL reset_ctrl: got %b required 0", {busy, done, in_ready, res_valid, res_row});
        n_tests++;
        if ({arr_a, arr_b, res_data, pe_clr, pe_read, pe_write} !== {(3*LW+75){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_data: arr_a %h arr_b %h res_data %h pe %h required all 0",
                     arr_a, arr_b, res_data, {pe_clr, pe_read, pe_write});
        end
        if ({busy, done, in_ready, res_valid, res_row} !== 7'd0) n_fail++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 5; k++) begin
                ma[i][k] = (i == k) ? N'(1) : N'(0);
                mb[k][i] = N'(5 * k + i + 1);
            end
        compute_ref(5);
        run_job(5, 0, 1'b0);
        id_lat = obs_lat;
        n_tests++;
        if (obs_lat != 26 || obs_ndone != 1) begin
            n_fail++;
            $display("FAIL identity_latency: got %0d cycles, %0d done pulses; required 26, 1", obs_lat, obs_ndone);
        end
        n_tests++;
        if (obs_nrows != 5 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_rows: got %0d rows busy %b; required 5 rows busy 0", obs_nrows, obs_busy);
        end
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== exp_c[4 - r]) begin
                n_fail++;
                $display("FAIL identity_row%0d: got row %0d data %h; required row %0d data %h",
                         r, obs_row[r], obs_data[r], 4 - r, exp_c[4 - r]);
            end
        end
    endtask

    task automatic test_stall();
        run_job(5, 1, 1'b0);
        n_tests++;
        if (obs_stalls == 0 || obs_lat != id_lat + obs_stalls) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d cycles with %0d stalls; required %0d", obs_lat, obs_stalls, id_lat + obs_stalls);
        end
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== exp_c[4 - r]) begin
                n_fail++;
                $display("FAIL stall_row%0d: got row %0d data %h; required row %0d data %h",
                         r, obs_row[r], obs_data[r], 4 - r, exp_c[4 - r]);
            end
        end
    endtask

    task automatic test_k1();
        for (int i = 0; i < 5; i++) begin
            ma[i][0] = N'(i + 1);
            mb[0][i] = N'(1);
        end
        compute_ref(1);
        run_job(1, 0, 1'b0);
        n_tests++;
        if (obs_lat != 22 || obs_nrows != 5) begin
            n_fail++;
            $display("FAIL k1_latency: got %0d cycles %0d rows; required 22 cycles 5 rows", obs_lat, obs_nrows);
        end
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== exp_c[4 - r]) begin
                n_fail++;
                $display("FAIL k1_row%0d: got row %0d data %h; required row %0d data %h",
                         r, obs_row[r], obs_data[r], 4 - r, exp_c[4 - r]);
            end
        end
    endtask

    task automatic test_k0();
        randomize_mats();
        run_job(0, 0, 1'b0);
        n_tests++;
        if (obs_lat != 21 || obs_ready != 0 || obs_ndone != 1) begin
            n_fail++;
            $display("FAIL k0_latency: got %0d cycles, in_ready high %0d cycles, %0d done; required 21, 0, 1",
                     obs_lat, obs_ready, obs_ndone);
        end
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== {LW{1'b0}}) begin
                n_fail++;
                $display("FAIL k0_row%0d: got row %0d data %h; required row %0d data 0", r, obs_row[r], obs_data[r], 4 - r);
            end
        end
    endtask

    task automatic test_back_to_back();
        randomize_mats();
        compute_ref(5);
        run_job(5, 0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== exp_c[4 - r]) begin
                n_fail++;
                $display("FAIL b2b_first_row%0d: got row %0d data %h; required row %0d data %h",
                         r, obs_row[r], obs_data[r], 4 - r, exp_c[4 - r]);
            end
        end
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 5; k++) begin
                ma[i][k] = N'(1);
                mb[k][i] = N'(1);
            end
        run_job(5, 0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== {5{N'(5)}}) begin
                n_fail++;
                $display("FAIL b2b_ones_row%0d: got row %0d data %h; required row %0d all 5", r, obs_row[r], obs_data[r], 4 - r);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 2; k++) begin
                ma[i][k] = N'(1) << (N / 2);
                mb[k][i] = N'(1) << (N / 2);
            end
        run_job(2, 0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== {LW{1'b0}}) begin
                n_fail++;
                $display("FAIL overflow_row%0d: got row %0d data %h; required row %0d data 0", r, obs_row[r], obs_data[r], 4 - r);
            end
        end
    endtask

    task automatic test_reset_midfeed();
        int sent, guard, base_done;
        randomize_mats();
        base_done = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0; guard = 0;
        while (sent < 3 && guard < 100) begin
            in_valid = 1'b1;
            a_col    = pack_a(sent);
            b_row    = pack_b(sent);
            @(negedge clk);
            if (in_ready) sent++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midfeed_prereset: got busy %b in_ready %b; required 1 1", busy, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, in_ready, res_valid, res_row, arr_a, arr_b, res_data, pe_clr, pe_read, pe_write}
            !== {(3*LW+82){1'b0}}) begin
            n_fail++;
            $display("FAIL midfeed_reset_outputs: busy %b in_ready %b arr_a %h arr_b %h pe %h; required all 0",
                     busy, in_ready, arr_a, arr_b, {pe_clr, pe_read, pe_write});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        n_tests++;
        if (done_cnt != base_done || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midfeed_abort: got %0d done pulses busy %b; required 0 pulses busy 0", done_cnt - base_done, busy);
        end
        randomize_mats();
        compute_ref(1);
        run_job(1, 0, 1'b1);
        n_tests++;
        if (obs_lat != 22 || obs_ndone != 1 || obs_busy !== 1'b0 || obs_nrows != 5) begin
            n_fail++;
            $display("FAIL midfeed_next_job: got %0d cycles %0d done busy %b %0d rows; required 22, 1, 0, 5",
                     obs_lat, obs_ndone, obs_busy, obs_nrows);
        end
        for (int r = 0; r < 5; r++) begin
            n_tests++;
            if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== exp_c[4 - r]) begin
                n_fail++;
                $display("FAIL midfeed_row%0d: got row %0d data %h; required row %0d data %h",
                         r, obs_row[r], obs_data[r], 4 - r, exp_c[4 - r]);
            end
        end
    endtask

    task automatic test_random();
        int k;
        for (int t = 0; t < 6; t++) begin
            k = $urandom_range(1, 12);
            randomize_mats();
            compute_ref(k);
            run_job(k, 2, 1'b0);
            n_tests++;
            if (obs_lat != 21 + k + obs_stalls || obs_ndone != 1) begin
                n_fail++;
                $display("FAIL random%0d_latency: K=%0d got %0d cycles %0d done; required %0d, 1",
                         t, k, obs_lat, obs_ndone, 21 + k + obs_stalls);
            end
            for (int r = 0; r < 5; r++) begin
                n_tests++;
                if (obs_row[r] !== 3'(4 - r) || obs_data[r] !== exp_c[4 - r]) begin
                    n_fail++;
                    $display("FAIL random%0d_row%0d: got row %0d data %h; required row %0d data %h",
                             t, r, obs_row[r], obs_data[r], 4 - r, exp_c[4 - r]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stall();
        test_k1();
        test_k0();
        test_back_to_back();
        test_overflow();
        test_reset_midfeed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
